cvita_to_vrlp: RTL
==================

# cvita_to_vrlp

Converts compressed-VITA (CHDR) packets into VRLP-framed VITA-49 frames for the outbound radio link path; it is the transmit-side counterpart of the VRLP-to-CHDR converter. Each input CHDR packet gets a VRLP header line, a regenerated VITA header/SID line, the passed-through time and payload lines, and a VEND trailer line. Framing is driven by the CHDR length field, which makes the output frame size always self-consistent.

## Interface
- FIFO_SIZE, 5: log2 depth of the output short FIFO (65 bits wide: tlast + data).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous, active-high. Same effect as reset on the FSM and FIFO.
- i_tdata  in  64  CHDR line.
- i_tlast  in  1  last CHDR line.
- i_tvalid  in  1  AXI-stream valid.
- i_tready  out  1  AXI-stream ready.
- o_tdata  out  64  VRLP frame line.
- o_tlast  out  1  last line of the frame (the VEND line).
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- err  out  1  one-cycle pulse on a length mismatch (pad or drop).

## Operation
**CHDR header fields**
- is_ec = [63]; has_trailer = [62]; has_time = [61]; eob = [60]; seqnum = [59:48]; len = [47:32] (bytes, header included); sid = [31:0].

**Derived values (registered at header acceptance)**
- vita_words = (len + 3) >> 2, 16-bit. If len < 8, use vita_words = 2.
- lines = (vita_words + 1) >> 1.
- frame_size = vita_words + 3, 20-bit. The 3 words are the VRLP word, the info word and the VEND word.

**VRLP line**
- {32'h56524C50, seqnum, frame_size[19:0]}.

**VITA header word**
- [31:28] = is_ec ? 4'h5 : 4'h1.
- [27] = 0.
- [26] = has_trailer & ~is_ec.
- [25] = 0.
- [24] = eob & ~is_ec.
- [23:22] = 0.
- [21:20] = has_time ? 2'b01 : 2'b00.
- [19:16] = seqnum[3:0].
- [15:0] = vita_words.

**VITA line**
- {vita_hdr, sid}.

**VEND line**
- {32'h56454E44, 32'h0}, with tlast = 1.

**FSM states**
- VRLP:
  - Wait for i_tvalid.
  - Present the VRLP line to the FIFO without consuming the input (i_tready = 0).
  - On FIFO accept, latch the derived values and go to VHDR.
- VHDR:
  - Present the VITA line and consume the CHDR header.
  - Load rem = lines − 1.
  - If rem == 0 and i_tlast: go to VEND.
  - If rem == 0 and not i_tlast: go to DROP and pulse err.
  - If rem > 0 and i_tlast: go to PAD and pulse err.
  - Otherwise: go to BODY.
- BODY:
  - Pass i_tdata through and decrement rem on each transfer.
  - If the line with rem == 1 is accepted: go to VEND if i_tlast, else go to DROP and pulse err.
  - If i_tlast arrives with rem > 1: go to PAD and pulse err.
- PAD:
  - Emit 64'h0 lines (i_tready = 0) until rem reaches 0, then go to VEND.
- DROP:
  - i_tready = 1, no output.
  - Discard input until i_tlast, then go to VEND.
- VEND:
  - Emit the VEND line (i_tready = 0), then go to VRLP.

**Handshake and ordering**
- i_tready = FIFO ready in VHDR and BODY; 1 in DROP; 0 otherwise.
- FIFO write valid is asserted only in VRLP (gated by i_tvalid), VHDR, BODY (gated by i_tvalid), PAD and VEND.
- tlast into the FIFO is 1 only in VEND.
- The output frame therefore always contains exactly lines + 2 lines.

## Timing
**Reset / clear**
- FSM returns to VRLP; FIFO is flushed.
- err = 0.
- o_tvalid = 0 on the cycle after the reset edge.
- Reset mid-packet abandons the frame; no VEND is emitted. The remainder of the input packet is then treated as a new header; this is an upstream responsibility.

**Latency**
- The FSM path is combinational into the FIFO; the FIFO adds 1 cycle.
- First o_tvalid appears 1 cycle after the VRLP line is written.

**Throughput and stalls**
- With o_tready held at 1, the sustained rate is 1 line/cycle. Each frame costs 2 overhead cycles (VRLP, VEND) during which the input is stalled.
- o_tready low: the FIFO fills and then FIFO ready drops, which stalls the FSM. No data is lost or duplicated.

**err**
- Registered; asserted for exactly the one cycle after the mismatching transfer.

**Widths**
- frame_size is a 20-bit zero-extended sum.
- len = 0xFFFF gives vita_words = 16384 and frame_size = 16387; there is no overflow.

## Test plan
- **Basic data packet:** seqnum 0x123, len 24, no time, 3 lines. Output 5 lines:
  - {56524C50, 12300009}
  - {10030006, sid}
  - 2 payload lines
  - {56454E44, 0} with tlast.
  - err stays 0.
- **Time + eob, odd word count:** len 20, seqnum 0x003. Output:
  - VRLP info 0x00300008
  - VITA header 0x11130005
  - time line, 1 payload line, VEND.
- **Extension context:** is_ec = 1, has_trailer = 1, eob = 1, len 16. VITA header = 0x50000004, with trailer and eob bits both cleared.
- **Short input:** len 32 (4 lines), i_tlast on line 2. Output:
  - header lines, 1 payload line, 2 zero lines, VEND
  - err pulses once
  - frame_size = 11.
- **Long input:** len 16 (2 lines), input packet of 5 lines. Output:
  - VRLP, VITA, 1 payload line, VEND
  - 3 input lines dropped with i_tready = 1
  - err pulses once.
- **Backpressure and reset:**
  - Random 50% o_tready over 100 back-to-back packets: output matches the reference model bit-exact.
  - Assert reset during BODY: o_tvalid = 0 next cycle, and the next clean packet is converted correctly.

Source files
------------

// File: rtl/cvita_to_vrlp.sv
`default_nettype none
// ============================================================================
//  Module      : cvita_to_vrlp
//  Description : Converts CHDR (compressed VITA) packets into VRLP-framed
//                VITA-49 frames. Each output frame is a VRLP header line, a
//                regenerated VITA header/SID line, the time and payload lines,
//                and a VEND trailer line. The frame length follows the CHDR
//                length field. Input packets that are too short are padded
//                with zero lines. Input packets that are too long are
//                truncated. Either case pulses err.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_SIZE  log2 depth of the output FIFO (65 bits wide: tlast + data)
//  Ports
//    clk, reset, clear        clock, sync active-high reset / clear
//    i_tdata/i_tlast/i_tvalid/i_tready   CHDR AXI-stream input
//    o_tdata/o_tlast/o_tvalid/o_tready   VRLP AXI-stream output
//    err                      one-cycle pulse on an input length mismatch
// ============================================================================
module cvita_to_vrlp #(
   parameter int FIFO_SIZE = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [63:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [63:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic        err
);

   localparam logic [2:0] c_ST_VRLP = 3'd0;
   localparam logic [2:0] c_ST_VHDR = 3'd1;
   localparam logic [2:0] c_ST_BODY = 3'd2;
   localparam logic [2:0] c_ST_PAD  = 3'd3;
   localparam logic [2:0] c_ST_DROP = 3'd4;
   localparam logic [2:0] c_ST_VEND = 3'd5;

   localparam logic [31:0]        c_VRLP_MAGIC = 32'h56524C50;
   localparam logic [31:0]        c_VEND_MAGIC = 32'h56454E44;
   localparam int                 c_DEPTH      = 1 << FIFO_SIZE;
   localparam logic [FIFO_SIZE:0] c_DEPTH_CNT  = (FIFO_SIZE+1)'(c_DEPTH);

   logic [2:0]  r_state;
   logic [15:0] r_vita_words;
   logic [15:0] r_lines;
   logic [15:0] r_rem;
   logic        r_err;

   logic [64:0]          r_mem [c_DEPTH];
   logic [FIFO_SIZE-1:0] r_wr_ptr;
   logic [FIFO_SIZE-1:0] r_rd_ptr;
   logic [FIFO_SIZE:0]   r_count;

   logic [16:0] w_len_rnd;
   logic [15:0] w_vita_words;
   logic [15:0] w_lines;
   logic [19:0] w_frame_size;
   logic [31:0] w_vita_hdr;
   logic        w_is_ec;
   logic        w_fifo_ready;
   logic        w_fifo_wvalid;
   logic [64:0] w_fifo_wdata;
   logic        w_in_ready;
   logic        w_in_xfer;
   logic        w_err_set;
   logic        w_push;
   logic        w_pop;

   // Header decode from the live input word. The header is held on the input
   // throughout VRLP and VHDR, because VRLP does not consume it.
   assign w_is_ec      = i_tdata[63];
   assign w_len_rnd    = {1'b0, i_tdata[47:32]} + 17'd3;
   assign w_vita_words = (i_tdata[47:32] < 16'd8) ? 16'd2 : {1'b0, w_len_rnd[16:2]};
   assign w_lines      = {1'b0, w_vita_words[15:1]} + {15'd0, w_vita_words[0]};
   assign w_frame_size = {4'd0, w_vita_words} + 20'd3;
   assign w_vita_hdr   = {(w_is_ec ? 4'h5 : 4'h1), 1'b0, i_tdata[62] & ~w_is_ec,
                          1'b0, i_tdata[60] & ~w_is_ec, 2'b00, 1'b0, i_tdata[61],
                          i_tdata[51:48], r_vita_words};

   assign w_fifo_ready = (r_count != c_DEPTH_CNT);
   assign i_tready     = w_in_ready;
   assign w_in_xfer    = i_tvalid & w_in_ready;
   assign err          = r_err;

   always_comb begin
      w_fifo_wvalid = 1'b0;
      w_fifo_wdata  = 65'd0;
      w_in_ready    = 1'b0;
      w_err_set     = 1'b0;
      case (r_state)
         c_ST_VRLP: begin
            w_fifo_wvalid = i_tvalid;
            w_fifo_wdata  = {1'b0, c_VRLP_MAGIC, i_tdata[59:48], w_frame_size};
         end
         c_ST_VHDR: begin
            // The header is already known valid from the VRLP state.
            w_fifo_wvalid = 1'b1;
            w_fifo_wdata  = {1'b0, w_vita_hdr, i_tdata[31:0]};
            w_in_ready    = w_fifo_ready;
            w_err_set     = w_fifo_ready & ((r_lines == 16'd1) != i_tlast);
         end
         c_ST_BODY: begin
            w_fifo_wvalid = i_tvalid;
            w_fifo_wdata  = {1'b0, i_tdata};
            w_in_ready    = w_fifo_ready;
            w_err_set     = w_in_xfer & ((r_rem == 16'd1) != i_tlast);
         end
         c_ST_PAD: begin
            w_fifo_wvalid = 1'b1;
         end
         c_ST_DROP: begin
            w_in_ready = 1'b1;
         end
         c_ST_VEND: begin
            w_fifo_wvalid = 1'b1;
            w_fifo_wdata  = {1'b1, c_VEND_MAGIC, 32'd0};
         end
         default: begin
            w_fifo_wvalid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_state      <= c_ST_VRLP;
         r_vita_words <= 16'd0;
         r_lines      <= 16'd0;
         r_rem        <= 16'd0;
         r_err        <= 1'b0;
      end else begin
         r_err <= w_err_set;
         case (r_state)
            c_ST_VRLP: begin
               if (i_tvalid && w_fifo_ready) begin
                  r_vita_words <= w_vita_words;
                  r_lines      <= w_lines;
                  r_state      <= c_ST_VHDR;
               end
            end
            c_ST_VHDR: begin
               if (w_fifo_ready) begin
                  r_rem <= r_lines - 16'd1;
                  if (r_lines == 16'd1)
                     r_state <= i_tlast ? c_ST_VEND : c_ST_DROP;
                  else
                     r_state <= i_tlast ? c_ST_PAD : c_ST_BODY;
               end
            end
            c_ST_BODY: begin
               if (w_in_xfer) begin
                  r_rem <= r_rem - 16'd1;
                  if (r_rem == 16'd1)
                     r_state <= i_tlast ? c_ST_VEND : c_ST_DROP;
                  else if (i_tlast)
                     r_state <= c_ST_PAD;
               end
            end
            c_ST_PAD: begin
               if (w_fifo_ready) begin
                  r_rem <= r_rem - 16'd1;
                  if (r_rem == 16'd1)
                     r_state <= c_ST_VEND;
               end
            end
            c_ST_DROP: begin
               if (i_tvalid && i_tlast)
                  r_state <= c_ST_VEND;
            end
            c_ST_VEND: begin
               if (w_fifo_ready)
                  r_state <= c_ST_VRLP;
            end
            default: r_state <= c_ST_VRLP;
         endcase
      end
   end

   // Output FIFO: a circular buffer whose head is presented directly.
   assign w_push   = w_fifo_wvalid & w_fifo_ready;
   assign w_pop    = o_tvalid & o_tready;
   assign o_tvalid = (r_count != '0);
   assign {o_tlast, o_tdata} = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_fifo_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (!w_push && w_pop)
            r_count <= r_count - 1'b1;
      end
   end

endmodule
`default_nettype wire
